// File: rtl/temporizador_regressivo_mmss.sv
// mm:ss countdown timer: a BCD down-counter chain (sec units, sec tens,
// min units, min tens) with borrow propagation. An IDLE/RUN/PAUSE/DONE FSM
// controls it. Decrements come from the external tick strobe when
// CLK_DIV=0, or from an internal prescaler every CLK_DIV clocks.
module temporizador_regressivo_mmss #(
  parameter int CLK_DIV = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [2:0] load_min_t,
  input  logic [3:0] load_min_u,
  input  logic [2:0] load_sec_t,
  input  logic [3:0] load_sec_u,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'((CLK_DIV > 0) ? CLK_DIV - 1 : 0);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nx;
  logic [2:0]    min_t_nx, sec_t_nx;
  logic [3:0]    min_u_nx, sec_u_nx;
  logic [PW-1:0] pre, pre_nx;
  logic          expired_nx;
  logic          dec_ev;
  logic          is_zero;
  logic          b_su, b_st, b_mu;

  function automatic logic [3:0] clamp_units(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  function automatic logic [2:0] clamp_tens(input logic [2:0] v);
    return (v > 3'd5) ? 3'd5 : v;
  endfunction

  assign running = (state == RUN);
  assign done    = (state == DONE);

  // Decrement strobe source and zero detect of the current count.
  always_comb begin
    dec_ev  = (CLK_DIV == 0) ? tick : (pre == PRE_MAX);
    is_zero = (min_t == 3'd0) && (min_u == 4'd0) &&
              (sec_t == 3'd0) && (sec_u == 4'd0);
  end

  // Next-state, borrow chain and prescaler logic; load beats pause beats start.
  always_comb begin
    state_nx   = state;
    min_t_nx   = min_t;
    min_u_nx   = min_u;
    sec_t_nx   = sec_t;
    sec_u_nx   = sec_u;
    pre_nx     = pre;
    expired_nx = 1'b0;
    b_su       = 1'b0;
    b_st       = 1'b0;
    b_mu       = 1'b0;
    if (load) begin
      min_t_nx = clamp_tens(load_min_t);
      min_u_nx = clamp_units(load_min_u);
      sec_t_nx = clamp_tens(load_sec_t);
      sec_u_nx = clamp_units(load_sec_u);
      pre_nx   = '0;
      state_nx = IDLE;
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_nx = PAUSE;
          end else begin
            if (CLK_DIV > 0) pre_nx = dec_ev ? '0 : pre + PW'(1);
            if (dec_ev) begin
              b_su     = (sec_u == 4'd0);
              sec_u_nx = b_su ? 4'd9 : sec_u - 4'd1;
              if (b_su) begin
                b_st     = (sec_t == 3'd0);
                sec_t_nx = b_st ? 3'd5 : sec_t - 3'd1;
              end
              if (b_su && b_st) begin
                b_mu     = (min_u == 4'd0);
                min_u_nx = b_mu ? 4'd9 : min_u - 4'd1;
              end
              if (b_su && b_st && b_mu)
                min_t_nx = (min_t == 3'd0) ? 3'd5 : min_t - 3'd1;
              // RUN never holds 00:00, so a zero result is always the last step.
              if ((min_t_nx == 3'd0) && (min_u_nx == 4'd0) &&
                  (sec_t_nx == 3'd0) && (sec_u_nx == 4'd0)) begin
                state_nx   = DONE;
                expired_nx = 1'b1;
              end
            end
          end
        end
        IDLE, PAUSE: begin
          if (start && !is_zero) begin
            state_nx = RUN;
            pre_nx   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // State, digit, prescaler and expiry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      min_t   <= 3'd0;
      min_u   <= 4'd0;
      sec_t   <= 3'd0;
      sec_u   <= 4'd0;
      pre     <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      min_t   <= min_t_nx;
      min_u   <= min_u_nx;
      sec_t   <= sec_t_nx;
      sec_u   <= sec_u_nx;
      pre     <= pre_nx;
      expired <= expired_nx;
    end
  end

endmodule

// File: tb/tb_temporizador_regressivo_mmss.sv
// Testbench for the mm:ss countdown timer. It drives two instances, one paced
// by tick and one with a divide-by-4 prescaler. A seconds-based reference
// model pushes the expected outputs of every cycle into per-instance queues,
// and a negedge monitor pops them and compares.
module tb_temporizador_regressivo_mmss;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tick, load, start, pause;
  logic [2:0] lmt, lst;
  logic [3:0] lmu, lsu;

  logic [2:0] a_min_t, a_sec_t, b_min_t, b_sec_t;
  logic [3:0] a_min_u, a_sec_u, b_min_u, b_sec_u;
  logic       a_running, a_done, a_expired, b_running, b_done, b_expired;

  temporizador_regressivo_mmss #(.CLK_DIV(0)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_min_t(lmt), .load_min_u(lmu), .load_sec_t(lst), .load_sec_u(lsu),
    .start(start), .pause(pause),
    .min_t(a_min_t), .min_u(a_min_u), .sec_t(a_sec_t), .sec_u(a_sec_u),
    .running(a_running), .done(a_done), .expired(a_expired)
  );

  temporizador_regressivo_mmss #(.CLK_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_min_t(lmt), .load_min_u(lmu), .load_sec_t(lst), .load_sec_u(lsu),
    .start(start), .pause(pause),
    .min_t(b_min_t), .min_u(b_min_u), .sec_t(b_sec_t), .sec_u(b_sec_u),
    .running(b_running), .done(b_done), .expired(b_expired)
  );

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  typedef struct {
    int st;
    int secs;
    int pre;
    bit exp;
  } mstate_t;

  mstate_t     m_a, m_b;
  logic [16:0] q_a[$], q_b[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  function automatic int clampi(int v, int hi);
    return (v > hi) ? hi : v;
  endfunction

  // Reference: the count is held as total seconds; a decrement subtracts one.
  function automatic mstate_t mstep(mstate_t m, int div);
    mstate_t n;
    bit      ev;
    n = m;
    n.exp = 1'b0;
    if (!reset) begin
      n.st = S_IDLE; n.secs = 0; n.pre = 0;
    end else if (load) begin
      n.secs = clampi(int'(lmt), 5) * 600 + clampi(int'(lmu), 9) * 60 +
               clampi(int'(lst), 5) * 10 + clampi(int'(lsu), 9);
      n.st = S_IDLE; n.pre = 0;
    end else if (m.st == S_RUN) begin
      if (pause) begin
        n.st = S_PAUSE;
      end else begin
        ev = (div == 0) ? tick : (m.pre == div - 1);
        if (div > 0) n.pre = ev ? 0 : m.pre + 1;
        if (ev) begin
          n.secs = m.secs - 1;
          if (n.secs == 0) begin
            n.st = S_DONE; n.exp = 1'b1;
          end
        end
      end
    end else if ((m.st == S_IDLE || m.st == S_PAUSE) && start && m.secs != 0) begin
      n.st = S_RUN; n.pre = 0;
    end
    return n;
  endfunction

  function automatic logic [16:0] mview(mstate_t m);
    return {3'(m.secs / 600), 4'((m.secs / 60) % 10), 3'((m.secs % 60) / 10),
            4'(m.secs % 10), m.st == S_RUN, m.st == S_DONE, m.exp};
  endfunction

  function automatic logic [13:0] bcd(int mt, int mu, int st, int su);
    return {3'(mt), 4'(mu), 3'(st), 4'(su)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  // One clock: advance both models on the edge, queue expectations, settle.
  task automatic step();
    @(posedge clk);
    cyc++;
    m_a = mstep(m_a, 0);
    m_b = mstep(m_b, 4);
    q_a.push_back(mview(m_a));
    q_b.push_back(mview(m_b));
    #1;
  endtask

  task automatic do_load(int mt, int mu, int st, int su);
    load = 1'b1; lmt = 3'(mt); lmu = 4'(mu); lst = 3'(st); lsu = 4'(su);
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  // Monitor: compare every presented output cycle against the queued model value.
  always @(negedge clk) begin
    logic [16:0] want;
    if (q_a.size() > 0) begin
      want = q_a.pop_front();
      checks++;
      if ({a_min_t, a_min_u, a_sec_t, a_sec_u, a_running, a_done, a_expired} !== want) begin
        failures++;
        $display("FAIL sb_div0 cyc=%0d got=%h want=%h", cyc,
                 {a_min_t, a_min_u, a_sec_t, a_sec_u, a_running, a_done, a_expired}, want);
      end
    end
    if (q_b.size() > 0) begin
      want = q_b.pop_front();
      checks++;
      if ({b_min_t, b_min_u, b_sec_t, b_sec_u, b_running, b_done, b_expired} !== want) begin
        failures++;
        $display("FAIL sb_div4 cyc=%0d got=%h want=%h", cyc,
                 {b_min_t, b_min_u, b_sec_t, b_sec_u, b_running, b_done, b_expired}, want);
      end
    end
  end

  initial begin
    m_a = '{S_IDLE, 0, 0, 1'b0};
    m_b = '{S_IDLE, 0, 0, 1'b0};
    reset = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    lmt = '0; lmu = '0; lst = '0; lsu = '0;

    step(); step();
    reset = 1'b1;
    chk("reset_a", {a_min_t, a_min_u, a_sec_t, a_sec_u, a_running, a_done, a_expired}, 0);
    chk("reset_b", {b_min_t, b_min_u, b_sec_t, b_sec_u, b_running, b_done, b_expired}, 0);

    do_load(0, 1, 3, 0);
    chk("load_0130", {a_min_t, a_min_u, a_sec_t, a_sec_u}, bcd(0, 1, 3, 0));
    chk("load_idle", {a_running, a_done}, 0);

    do_load(1, 0, 0, 0);
    pulse_start();
    ticks(1);
    chk("borrow_0959", {a_min_t, a_min_u, a_sec_t, a_sec_u}, bcd(0, 9, 5, 9));
    ticks(59);
    chk("borrow_0900", {a_min_t, a_min_u, a_sec_t, a_sec_u}, bcd(0, 9, 0, 0));

    do_load(0, 0, 0, 2);
    pulse_start();
    ticks(1);
    chk("exp_pre", {a_done, a_expired}, 0);
    ticks(1);
    chk("exp_zero", {a_min_t, a_min_u, a_sec_t, a_sec_u}, 0);
    chk("exp_pulse", {a_running, a_done, a_expired}, 3'b011);
    step();
    chk("exp_once", {a_done, a_expired}, 2'b10);
    ticks(3);
    chk("exp_hold", {a_min_t, a_min_u, a_sec_t, a_sec_u, a_done}, 15'd1);

    do_load(0, 0, 1, 0);
    pulse_start();
    ticks(3);
    chk("run_0007", {a_min_t, a_min_u, a_sec_t, a_sec_u}, bcd(0, 0, 0, 7));
    pause = 1'b1; step(); pause = 1'b0;
    ticks(5);
    chk("pause_hold", {a_min_t, a_min_u, a_sec_t, a_sec_u, a_running}, {bcd(0, 0, 0, 7), 1'b0});
    pulse_start();
    ticks(1);
    chk("resume_0006", {a_min_t, a_min_u, a_sec_t, a_sec_u}, bcd(0, 0, 0, 6));

    pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
    chk("pause_tick", {a_min_t, a_min_u, a_sec_t, a_sec_u, a_running}, {bcd(0, 0, 0, 6), 1'b0});
    start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
    chk("start_tick", {a_min_t, a_min_u, a_sec_t, a_sec_u, a_running}, {bcd(0, 0, 0, 6), 1'b1});
    ticks(1);
    chk("after_start", {a_min_t, a_min_u, a_sec_t, a_sec_u}, bcd(0, 0, 0, 5));
    tick = 1'b1;
    do_load(0, 5, 0, 0);
    tick = 1'b0;
    chk("load_tick", {a_min_t, a_min_u, a_sec_t, a_sec_u, a_running}, {bcd(0, 5, 0, 0), 1'b0});

    do_load(7, 15, 7, 12);
    chk("clamp_5959", {a_min_t, a_min_u, a_sec_t, a_sec_u}, bcd(5, 9, 5, 9));

    do_load(0, 0, 0, 0);
    pulse_start();
    chk("start_zero", {a_running, a_done, a_expired}, 0);

    do_load(0, 0, 0, 1);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("div4_wait", {b_done, b_expired}, 0);
    end
    step();
    chk("div4_done", {b_min_t, b_min_u, b_sec_t, b_sec_u, b_done, b_expired}, 16'b11);

    do_load(0, 3, 0, 0);
    pulse_start();
    ticks(5);
    reset = 1'b0; tick = 1'b1;
    step();
    reset = 1'b1; tick = 1'b0;
    chk("reset_run", {a_min_t, a_min_u, a_sec_t, a_sec_u, a_running, a_done, a_expired}, 0);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      load  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 0) begin
        lmt = 3'd0; lmu = 4'd0; lst = 3'($urandom_range(0, 1)); lsu = 4'($urandom_range(0, 9));
      end else begin
        lmt = 3'($urandom_range(0, 7)); lmu = 4'($urandom_range(0, 15));
        lst = 3'($urandom_range(0, 7)); lsu = 4'($urandom_range(0, 15));
      end
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 15) == 0);
      tick  = ($urandom_range(0, 1) == 0);
      step();
    end
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
